// File: rtl/hd_timing_pkg.sv
// Shared encodings for the HD-CPU beat/phase timer.
//  W1_B..W3_B : one-hot beat codes driven on W[3:1]
//  state_t    : HALT / RUN sequencer state
//  phase_t    : T1..T3 phase within a beat
//  w_legal    : true for exactly one of the three beat codes
//  w_next     : beat-to-beat transition, given the SHORT/LONG requests
package hd_timing_pkg;

  localparam logic [2:0] W1_B = 3'b001;
  localparam logic [2:0] W2_B = 3'b010;
  localparam logic [2:0] W3_B = 3'b100;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    PH_T1 = 2'd0,
    PH_T2 = 2'd1,
    PH_T3 = 2'd2
  } phase_t;

  function automatic logic w_legal(input logic [2:0] w);
    return (w == W1_B) || (w == W2_B) || (w == W3_B);
  endfunction

  // SHORT only matters in W1 and wins over LONG there; LONG only matters in W2.
  function automatic logic [2:0] w_next(input logic [2:0] w, input logic short_i,
                                        input logic long_i);
    logic [2:0] n;
    case (w)
      W1_B:    n = short_i ? W1_B : W2_B;
      W2_B:    n = long_i  ? W3_B : W1_B;
      default: n = W1_B;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/hd_start_sync.sv
// Start-key conditioner: SYNC_STAGES flip-flop synchroniser on the
// asynchronous QD level followed by a rising-edge detector.
//  i_clk   : system clock
//  i_rst   : asynchronous reset, active-high (clears the chain)
//  i_qd    : raw start key level
//  o_start : 1-cycle pulse, SYNC_STAGES cycles after QD rises
module hd_start_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_qd,
  output logic o_start
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_qd};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Both terms are flops, so the pulse is clean inside the clock domain.
  assign o_start = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/hd_beat_timer.sv
// Beat/phase timing generator for the HD-CPU hardwired controller.
// Generates the one-hot beat W[3:1] and phase T1..T3, and closes the loop
// with the controller's SHORT/LONG/STOP requests, sampled on BEAT_END.
//  CLK, CLR      : clock, asynchronous active-high reset
//  QD            : start key (async level, rising edge starts/resumes)
//  SHORT/LONG/STOP : controller requests, honoured only in the BEAT_END cycle
//  W[2:0]        : one-hot beat (bit0 = W1)
//  T1,T2,T3      : one-hot phase, all 0 while halted
//  RUN           : sequencing active
//  BEAT_END      : 1-cycle pulse on the last CLK of T3
// Build option: define HD_SINGLE_BEAT_EN to stop after every beat
// (one beat per QD edge); otherwise run continues until STOP is sampled.
module hd_beat_timer
  import hd_timing_pkg::*;
#(
  parameter int PHASE_CYCLES = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       QD,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic       STOP,
  output logic [2:0] W,
  output logic       T1,
  output logic       T2,
  output logic       T3,
  output logic       RUN,
  output logic       BEAT_END
);

  localparam int             CW       = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PHASE_CYCLES - 1);

  state_t        r_state, w_state_nxt;
  phase_t        r_phase, w_phase_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_w, w_w_nxt;
  logic [3:1]    r_t, w_t_nxt;
  logic          r_be, w_be_nxt;
  logic          w_start;
  logic          w_stop;

  hd_start_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (CLK),
    .i_rst   (CLR),
    .i_qd    (QD),
    .o_start (w_start)
  );

`ifdef HD_SINGLE_BEAT_EN
  // Implicit STOP at every beat end; STOP kept in the expression so the
  // port stays connected to logic in both builds.
  assign w_stop = STOP | 1'b1;
`else
  assign w_stop = STOP;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_w_nxt     = r_w;
    case (r_state)
      ST_HALT: begin
        if (w_start) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = PH_T1;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (r_be) begin
          // r_be marks the last T3 cycle: the only cycle requests are seen.
          w_w_nxt     = w_next(r_w, SHORT, LONG);
          w_phase_nxt = PH_T1;
          w_cnt_nxt   = '0;
          if (w_stop) w_state_nxt = ST_HALT;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          case (r_phase)
            PH_T1:   w_phase_nxt = PH_T2;
            PH_T2:   w_phase_nxt = PH_T3;
            default: w_phase_nxt = PH_T1;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase

    // Recover from an upset beat register on the very next edge.
    if (!w_legal(r_w)) w_w_nxt = W1_B;

    // Outputs are decoded from next-state and registered, so T1..T3 and
    // BEAT_END come straight off flops and cannot glitch.
    w_t_nxt = '0;
    if (w_state_nxt == ST_RUN) begin
      case (w_phase_nxt)
        PH_T1:   w_t_nxt = 3'b001;
        PH_T2:   w_t_nxt = 3'b010;
        PH_T3:   w_t_nxt = 3'b100;
        default: w_t_nxt = '0;
      endcase
    end
    w_be_nxt = (w_state_nxt == ST_RUN) && (w_phase_nxt == PH_T3) &&
               (w_cnt_nxt == CNT_LAST);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_HALT;
      r_phase <= PH_T1;
      r_cnt   <= '0;
      r_w     <= W1_B;
      r_t     <= '0;
      r_be    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_w     <= w_w_nxt;
      r_t     <= w_t_nxt;
      r_be    <= w_be_nxt;
    end
  end

  assign W        = r_w;
  assign T1       = r_t[1];
  assign T2       = r_t[2];
  assign T3       = r_t[3];
  assign RUN      = (r_state == ST_RUN);
  assign BEAT_END = r_be;

endmodule

// File: tb/tb_hd_beat_timer.sv
// Bench for hd_beat_timer: two instances (PHASE_CYCLES=1 and 4) share the
// stimulus; a beat-level reference model (beat number, position in beat,
// running flag) predicts W/T/RUN/BEAT_END for each after every clock.
module tb_hd_beat_timer;

  localparam int SYNC = 2;

  logic CLK, CLR, QD, SHORT, LONG, STOP;
  logic [2:0] W_a, W_b;
  logic T1_a, T2_a, T3_a, RUN_a, BE_a;
  logic T1_b, T2_b, T3_b, RUN_b, BE_b;

  hd_beat_timer #(.PHASE_CYCLES(1), .SYNC_STAGES(SYNC)) dut_a (
    .CLK(CLK), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
    .W(W_a), .T1(T1_a), .T2(T2_a), .T3(T3_a), .RUN(RUN_a), .BEAT_END(BE_a));

  hd_beat_timer #(.PHASE_CYCLES(4), .SYNC_STAGES(SYNC)) dut_b (
    .CLK(CLK), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
    .W(W_b), .T1(T1_b), .T2(T2_b), .T3(T3_b), .RUN(RUN_b), .BEAT_END(BE_b));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state, index 0 -> dut_a, 1 -> dut_b.
  int m_run[2];
  int m_beat[2];   // 1, 2 or 3
  int m_pos[2];    // cycle index within the beat, 0 .. 3*pc-1
  logic [7:0] qhist;  // qhist[k] = QD seen k edges ago

  function automatic int pc(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] obs(input int d);
    if (d == 0) return {W_a, T1_a, T2_a, T3_a, RUN_a, BE_a};
    return {W_b, T1_b, T2_b, T3_b, RUN_b, BE_b};
  endfunction

  function automatic logic [7:0] expv(input int d);
    logic [2:0] w;
    logic [2:0] t;
    int ph;
    w  = (m_beat[d] == 1) ? 3'b001 : (m_beat[d] == 2) ? 3'b010 : 3'b100;
    ph = m_pos[d] / pc(d);
    t  = '0;
    if (m_run[d] != 0) t = (ph == 0) ? 3'b100 : (ph == 1) ? 3'b010 : 3'b001;
    return {w, t, (m_run[d] != 0),
            (m_run[d] != 0) && (m_pos[d] == 3 * pc(d) - 1)};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_beat[d] = 1; m_pos[d] = 0;
    end
    qhist = '0;
  endtask

  // Advance one clock and update the model from the inputs at that edge.
  task automatic tick();
    logic start;
    bit stop_eff;
    @(posedge CLK);
    cyc++;
    if (!CLR) begin
      qhist = {qhist[6:0], QD};
      // A rising edge becomes visible SYNC edges late; it starts on the next.
      start = qhist[SYNC] & ~qhist[SYNC+1];
`ifdef HD_SINGLE_BEAT_EN
      stop_eff = 1'b1;
`else
      stop_eff = STOP;
`endif
      for (int d = 0; d < 2; d++) begin
        if (m_run[d] != 0) begin
          if (m_pos[d] == 3 * pc(d) - 1) begin
            if (m_beat[d] == 1)      m_beat[d] = SHORT ? 1 : 2;
            else if (m_beat[d] == 2) m_beat[d] = LONG ? 3 : 1;
            else                     m_beat[d] = 1;
            m_pos[d] = 0;
            if (stop_eff) m_run[d] = 0;
          end else begin
            m_pos[d]++;
          end
        end else if (start) begin
          m_run[d] = 1;
          m_pos[d] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== 8'b001_000_0_0) begin
        errors++;
        $display("FAIL reset dut%0d got %b exp %b", d, obs(d), 8'b001_000_0_0);
      end
    end
    release_reset();
  endtask

  task automatic test_free_run();
    SHORT = 0; LONG = 0; STOP = 0; QD = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) QD = 0;
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL free_run dut%0d cyc %0d got %b exp %b", d, cyc, obs(d), expv(d));
        end
      end
    end
  endtask

  task automatic test_long_short();
    // LONG then SHORT dominated phases, then both randomly mixed.
    for (int i = 0; i < 150; i++) begin
      LONG  = (i < 50) ? 1'b1 : (i < 100) ? 1'b0 : 1'($urandom_range(0, 1));
      SHORT = (i < 50) ? 1'b0 : (i < 100) ? 1'b1 : 1'($urandom_range(0, 1));
      QD    = ((i % 10) < 5);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL long_short dut%0d cyc %0d got %b exp %b", d, cyc, obs(d), expv(d));
        end
      end
    end
    QD = 0; SHORT = 0; LONG = 0;
  endtask

  task automatic test_stop_restart();
    int n;
    bit seen;
    SHORT = 1; STOP = 1; QD = 0;
    n = 0;
    while ((m_run[0] != 0 || m_run[1] != 0) && n < 60) begin
      tick(); n++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL stop dut%0d cyc %0d got %b exp %b", d, cyc, obs(d), expv(d));
        end
      end
    end
    checks++;
    if (RUN_a !== 1'b0 || {T1_a, T2_a, T3_a} !== 3'b000 || W_a !== 3'b001) begin
      errors++;
      $display("FAIL stop_halt got run=%b t=%b w=%b exp run=0 t=000 w=001",
               RUN_a, {T1_a, T2_a, T3_a}, W_a);
    end
    STOP = 0; SHORT = 0;
    repeat (4) tick();
    QD = 1;
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      tick(); n++;
      seen = T1_a;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL restart dut%0d cyc %0d got %b exp %b", d, cyc, obs(d), expv(d));
        end
      end
    end
    checks++;
    if (!seen || n != 3) begin
      errors++;
      $display("FAIL restart_latency got %0d cycles (seen=%0d) exp 3", n, seen);
    end
    QD = 0;
  endtask

  task automatic test_qd_ignore_and_clr();
    int n;
    // QD chatter while running, then QD held high through a halt.
    STOP = 0; SHORT = 0; LONG = 0;
    for (int i = 0; i < 60; i++) begin
      if (i < 30) QD = 1'($urandom_range(0, 1));
      else begin QD = 1; STOP = (i < 50); end
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL qd_ignore dut%0d cyc %0d got %b exp %b", d, cyc, obs(d), expv(d));
        end
      end
    end
    checks++;
    if (RUN_a !== 1'b0) begin
      errors++;
      $display("FAIL qd_held got run=%b exp 0", RUN_a);
    end
    // Steer dut_a into W2/T2 then hit CLR mid-beat.
    STOP = 0; LONG = 0; SHORT = 0;
    n = 0;
    while (!(m_run[0] != 0 && m_beat[0] == 2 && m_pos[0] == 1) && n < 100) begin
      QD = ((n % 8) >= 4);
      tick(); n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL reach_w2t2 got timeout after %0d cycles exp W2/T2", n);
    end
    CLR = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({W_a, T1_a, T2_a, T3_a, RUN_a, BE_a} !== 8'b001_000_0_0) begin
      errors++;
      $display("FAIL clr_mid got %b exp %b", {W_a, T1_a, T2_a, T3_a, RUN_a, BE_a}, 8'b001_000_0_0);
    end
    QD = 0;
    release_reset();
  endtask

  task automatic test_phase4();
    int cnt;
    int exp_cnt;
    SHORT = 0; LONG = 0; STOP = 0; QD = 1;
    repeat (3) tick();
    QD = 0;
    while (T1_b !== 1'b1 && cyc < 90000) tick();
`ifdef HD_SINGLE_BEAT_EN
    exp_cnt = 1;
`else
    exp_cnt = 4;
`endif
    cnt = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (BE_b) cnt++;
      checks++;
      if (obs(1) !== expv(1)) begin
        errors++;
        $display("FAIL phase4 cyc %0d got %b exp %b", cyc, obs(1), expv(1));
      end
    end
    checks++;
    if (cnt != exp_cnt) begin
      errors++;
      $display("FAIL phase4_beat_end_count got %0d exp %0d", cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      SHORT = 1'($urandom_range(0, 1));
      LONG  = 1'($urandom_range(0, 1));
      STOP  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) QD = ~QD;
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d got %b exp %b", d, cyc, obs(d), expv(d));
        end
      end
    end
  endtask

  initial begin
    CLR = 1; QD = 0; SHORT = 0; LONG = 0; STOP = 0;
    model_reset();
    test_reset();
    test_free_run();
    test_long_short();
    test_stop_restart();
    test_qd_ignore_and_clr();
    test_reset();
    test_phase4();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
